// File: rtl/ft245_pkg.sv
// Shared types and default timing for the FT245 asynchronous bus scheduler.
package ft245_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OE,
        ST_RD_STROBE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_RECOVER,
        ST_SIWU
    } state_t;

    localparam logic REQ_MCP = 1'b0;
    localparam logic REQ_CCD = 1'b1;

    localparam int DEF_RD_PULSE    = 4;
    localparam int DEF_WR_PULSE    = 4;
    localparam int DEF_GAP         = 2;
    localparam int DEF_SIWU_PULSE  = 2;
    localparam int DEF_SYNC_STAGES = 2;

    localparam int CNT_W = 8;

endpackage

// File: rtl/ft_input_sync.sv
// N-stage synchroniser for the active-low FT232H status flags; resets to the idle (high) level.
module ft_input_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/ft245_bus_scheduler.sv
// Half-duplex FT245 async bus owner: host command reads plus round-robin writes from the
// MCP sampler (req0) and the CCD pixel stream (req1, packet-locked).
module ft245_bus_scheduler
    import ft245_pkg::*;
#(
    parameter int RD_PULSE    = DEF_RD_PULSE,
    parameter int WR_PULSE    = DEF_WR_PULSE,
    parameter int GAP         = DEF_GAP,
    parameter int SIWU_PULSE  = DEF_SIWU_PULSE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       clk_in,
    input  logic       rst,
    inout  wire  [7:0] ft_bus,
    input  logic       ft_rxf_n,
    input  logic       ft_txe_n,
    output logic       ft_rd_n,
    output logic       ft_wr_n,
    output logic       ft_oe_n,
    output logic       ft_siwu_n,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       busy
);

    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] SIWU_LAST = CNT_W'(SIWU_PULSE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_dispatch;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rxf_s;
    logic             w_txe_s;
    logic             r_rr_ptr;
    logic             r_lock;
    logic             r_gnt;
    logic             r_wr_flag;
    logic             r_last1;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_cmd_data;
    logic             r_cmd_valid;
    logic             w_gnt;
    logic             w_gnt_valid;
    logic [7:0]       w_gnt_data;
    logic             w_drive;
    logic [7:0]       w_bus_out;

    ft_input_sync #(.STAGES(SYNC_STAGES)) u_rxf_sync (
        .clk_in  (clk_in),
        .rst     (rst),
        .i_async (ft_rxf_n),
        .o_sync  (w_rxf_s)
    );

    ft_input_sync #(.STAGES(SYNC_STAGES)) u_txe_sync (
        .clk_in  (clk_in),
        .rst     (rst),
        .i_async (ft_txe_n),
        .o_sync  (w_txe_s)
    );

    // Round-robin pick; an open CCD packet owns the grant until its last byte.
    always_comb begin
        w_gnt = REQ_MCP;
        if (r_lock) begin
            w_gnt = REQ_CCD;
        end else if (r_rr_ptr == REQ_MCP) begin
            w_gnt = (req0_valid || !req1_valid) ? REQ_MCP : REQ_CCD;
        end else begin
            w_gnt = (req1_valid || !req0_valid) ? REQ_CCD : REQ_MCP;
        end
        w_gnt_valid = (w_gnt == REQ_CCD) ? req1_valid : req0_valid;
        w_gnt_data  = (r_gnt == REQ_CCD) ? req1_data  : req0_data;
    end

    // Reads win over writes; the same decision is taken from IDLE and from the
    // last RECOVER cycle so back-to-back bytes cost no extra idle cycle.
    always_comb begin
        w_dispatch = ST_IDLE;
        if (!w_rxf_s) begin
            w_dispatch = ST_RD_OE;
        end else if (!w_txe_s && w_gnt_valid) begin
            w_dispatch = ST_WR_SETUP;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ft_rd_n     = 1'b1;
        ft_wr_n     = 1'b1;
        ft_oe_n     = 1'b1;
        ft_siwu_n   = 1'b1;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_drive     = 1'b0;
        w_bus_out   = r_wr_data;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = w_dispatch;
            end
            ST_RD_OE: begin
                ft_oe_n     = 1'b0;
                w_state_nxt = ST_RD_STROBE;
            end
            ST_RD_STROBE: begin
                ft_oe_n = 1'b0;
                ft_rd_n = 1'b0;
                if (r_cnt == RD_LAST) w_state_nxt = ST_RECOVER;
            end
            ST_WR_SETUP: begin
                w_drive     = 1'b1;
                w_bus_out   = w_gnt_data;
                req0_ready  = (r_gnt == REQ_MCP);
                req1_ready  = (r_gnt == REQ_CCD);
                w_state_nxt = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                w_drive = 1'b1;
                ft_wr_n = 1'b0;
                if (r_cnt == WR_LAST) w_state_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                // Hold data past the WR# rising edge, but always leave a Z cycle before OE#.
                w_drive = r_wr_flag && (r_cnt == '0) && (GAP > 1);
                if (r_cnt == GAP_LAST) w_state_nxt = r_last1 ? ST_SIWU : w_dispatch;
            end
            ST_SIWU: begin
                ft_siwu_n = 1'b0;
                if (r_cnt == SIWU_LAST) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rr_ptr    <= REQ_MCP;
            r_lock      <= 1'b0;
            r_gnt       <= REQ_MCP;
            r_wr_flag   <= 1'b0;
            r_last1     <= 1'b0;
            r_wr_data   <= '0;
            r_cmd_data  <= '0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_valid <= 1'b0;
            if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((w_state_nxt == ST_WR_SETUP) && (r_state != ST_WR_SETUP)) begin
                r_gnt <= w_gnt;
            end
            case (r_state)
                ST_RD_OE: begin
                    r_wr_flag <= 1'b0;
                    r_last1   <= 1'b0;
                end
                ST_RD_STROBE: begin
                    if (r_cnt == RD_LAST) begin
                        r_cmd_data  <= ft_bus;
                        r_cmd_valid <= 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    r_wr_data <= w_gnt_data;
                    r_wr_flag <= 1'b1;
                    r_last1   <= (r_gnt == REQ_CCD) && req1_last;
                    if (r_gnt == REQ_MCP) begin
                        r_rr_ptr <= REQ_CCD;
                    end else if (req1_last) begin
                        r_lock   <= 1'b0;
                        r_rr_ptr <= REQ_MCP;
                    end else begin
                        r_lock   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ft_bus    = w_drive ? w_bus_out : 8'bz;
    assign cmd_data  = r_cmd_data;
    assign cmd_valid = r_cmd_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ft245_bus_scheduler.sv
// Directed bench for ft245_bus_scheduler: host/requester models, transaction scoreboard and per-cycle protocol checks.
module tb_ft245_bus_scheduler;

    localparam int RD_PULSE   = 4;
    localparam int WR_PULSE   = 4;
    localparam int SIWU_PULSE = 2;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    wire  [7:0] ft_bus;
    logic       ft_rxf_n = 1'b1;
    logic       ft_txe_n = 1'b1;
    logic       ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic [7:0] req0_data = 8'h00;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_last = 1'b0;
    logic       req1_ready;
    logic       busy;
    logic [7:0] host_byte = 8'h00;

    ft245_bus_scheduler dut (
        .clk_in(clk_in), .rst(rst), .ft_bus(ft_bus), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
        .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_oe_n(ft_oe_n), .ft_siwu_n(ft_siwu_n),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // Host side: FT232H drives the bus only while OE# is low.
    assign ft_bus = (!ft_oe_n) ? host_byte : 8'hzz;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] host_q[$];
    logic [7:0] cmd_exp[$];
    logic [7:0] r0_q[$];
    logic [8:0] r1_q[$];
    logic [8:0] exp_q[$];
    int         rdy_cyc[$];
    int         cyc = 0;
    int         cmd_cyc = 0;
    int         cmd_cnt = 0;
    int         wr_cnt = 0;
    int         siwu_cnt = 0;
    int         siwu_fall_cyc = 0;

    task automatic chk(input string nm, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Requester sources: hold valid/data until the accept pulse, then present the next entry.
    initial begin
        logic a0, a1;
        forever begin
            @(negedge clk_in);
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk_in);
            #1;
            if (a0 && r0_q.size() > 0) void'(r0_q.pop_front());
            if (a1 && r1_q.size() > 0) void'(r1_q.pop_front());
            req0_valid = (r0_q.size() > 0);
            req0_data  = req0_valid ? r0_q[0] : 8'h00;
            req1_valid = (r1_q.size() > 0);
            req1_data  = req1_valid ? r1_q[0][7:0] : 8'h00;
            req1_last  = req1_valid ? r1_q[0][8] : 1'b0;
        end
    end

    // Host: RXF# low while data is queued, drops on RD# fall, next byte after RD# rises.
    initial begin
        logic prv_rd, rd_now;
        prv_rd = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            rd_now = ft_rd_n;
            if (!prv_rd && rd_now && host_q.size() > 0) void'(host_q.pop_front());
            prv_rd    = rd_now;
            ft_rxf_n  = (host_q.size() == 0) || !rd_now;
            host_byte = (host_q.size() > 0) ? host_q[0] : 8'h00;
        end
    end

    // Per-cycle checker against the transaction-level expectations.
    initial begin
        logic       p_rd, p_wr, p_oe, p_siwu, p_r0, p_r1, p_cv, id, siwu_pend;
        logic [7:0] d, exp_wr_byte;
        logic [8:0] e;
        int         rd_run, wr_run, siwu_run, since_wr;
        p_rd = 1; p_wr = 1; p_oe = 1; p_siwu = 1; p_r0 = 0; p_r1 = 0; p_cv = 0;
        rd_run = 0; wr_run = 0; siwu_run = 0; since_wr = 100; siwu_pend = 0; exp_wr_byte = 0;
        forever begin
            @(negedge clk_in);
            if (rst) begin
                p_rd = 1; p_wr = 1; p_oe = 1; p_siwu = 1; p_r0 = 0; p_r1 = 0; p_cv = 0;
                rd_run = 0; wr_run = 0; siwu_run = 0; since_wr = 100; siwu_pend = 0;
                continue;
            end
            cyc++;
            if (req0_ready || req1_ready) begin
                chk("ready_onehot", int'(req0_ready && req1_ready), 0);
                chk("ready_width", int'((req0_ready && p_r0) || (req1_ready && p_r1)), 0);
                id = req1_ready;
                d  = id ? req1_data : req0_data;
                chk("ready_with_valid", int'(id ? req1_valid : req0_valid), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", int'({id, d}), 'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", int'(id), int'(e[8]));
                    chk("grant_data", int'(d), int'(e[7:0]));
                end
                exp_wr_byte = d;
                if (id && req1_last) siwu_pend = 1;
                rdy_cyc.push_back(cyc);
            end
            if (!ft_wr_n) begin
                chk("wr_bus", int'(ft_bus), int'(exp_wr_byte));
                if (p_wr) wr_cnt++;
                wr_run++;
                since_wr = 0;
            end else if (since_wr < 100) begin
                since_wr++;
            end
            if (!p_wr && ft_wr_n) begin
                chk("wr_pulse_len", wr_run, WR_PULSE);
                wr_run = 0;
            end
            if (!ft_oe_n && p_oe) chk("oe_gap_after_wr", int'(since_wr >= 3), 1);
            if (!ft_rd_n) begin
                if (p_rd) chk("oe_leads_rd", int'(p_oe), 0);
                rd_run++;
            end
            if (!p_rd && ft_rd_n) begin
                chk("rd_pulse_len", rd_run, RD_PULSE);
                rd_run = 0;
            end
            if (!ft_siwu_n) begin
                if (p_siwu) begin
                    chk("siwu_after_ccd_last", int'(siwu_pend), 1);
                    siwu_pend = 0;
                    siwu_fall_cyc = cyc;
                    siwu_cnt++;
                end
                siwu_run++;
            end
            if (!p_siwu && ft_siwu_n) begin
                chk("siwu_pulse_len", siwu_run, SIWU_PULSE);
                siwu_run = 0;
            end
            if (cmd_valid) begin
                chk("cmd_valid_width", int'(p_cv), 0);
                if (cmd_exp.size() == 0) chk("unexpected_cmd", int'(cmd_data), 'h1ff);
                else chk("cmd_data", int'(cmd_data), int'(cmd_exp.pop_front()));
                cmd_cyc = cyc;
                cmd_cnt++;
            end
            if (!ft_rd_n || !ft_wr_n || !ft_oe_n || !ft_siwu_n) chk("busy_active", int'(busy), 1);
            p_rd = ft_rd_n; p_wr = ft_wr_n; p_oe = ft_oe_n; p_siwu = ft_siwu_n;
            p_r0 = req0_ready; p_r1 = req1_ready; p_cv = cmd_valid;
        end
    end

    task automatic wait_done(input string nm);
        int n, quiet;
        n = 0;
        quiet = 0;
        while (quiet < 5 && n < 3000) begin
            @(negedge clk_in);
            n++;
            if (exp_q.size() == 0 && cmd_exp.size() == 0 && host_q.size() == 0 && !busy) quiet++;
            else quiet = 0;
        end
        if (n >= 3000) chk({nm, "_timeout"}, n, 0);
    endtask

    task automatic wait_ready_count(input int k, input string nm);
        int n;
        n = 0;
        while (rdy_cyc.size() < k && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 500) chk({nm, "_timeout"}, n, 0);
    endtask

    initial begin
        int n, c0, w0, s0, bad;

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst_rd_n", int'(ft_rd_n), 1);
        chk("rst_wr_n", int'(ft_wr_n), 1);
        chk("rst_oe_n", int'(ft_oe_n), 1);
        chk("rst_siwu_n", int'(ft_siwu_n), 1);
        chk("rst_cmd", int'({cmd_valid, cmd_data}), 0);
        chk("rst_ready", int'({req0_ready, req1_ready}), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);

        // Host reads F0..F3 with TXE# high
        c0 = cmd_cnt;
        for (int i = 0; i < 4; i++) begin
            host_q.push_back(8'hF0 + 8'(i));
            cmd_exp.push_back(8'hF0 + 8'(i));
        end
        n = 0;
        while (ft_rxf_n && n < 20) begin @(negedge clk_in); n++; end
        n = 0;
        while (ft_rd_n && n < 20) begin @(negedge clk_in); n++; end
        chk("rd_latency", n, 4);
        while (!cmd_valid && n < 40) begin @(negedge clk_in); n++; end
        chk("cmd_latency", n, 8);
        wait_done("t1");
        chk("t1_cmd_count", cmd_cnt - c0, 4);

        // Single MCP byte
        ft_txe_n = 1'b0;
        w0 = wr_cnt; s0 = siwu_cnt;
        r0_q.push_back(8'hA5);
        exp_q.push_back({1'b0, 8'hA5});
        wait_done("t2");
        chk("t2_wr_strobes", wr_cnt - w0, 1);
        chk("t2_no_siwu", siwu_cnt - s0, 0);

        // CCD packet with MCP contending throughout
        rdy_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            r1_q.push_back({(i == 3), 8'h10 + 8'(i)});
            exp_q.push_back({1'b1, 8'h10 + 8'(i)});
        end
        r0_q.push_back(8'h5A);
        exp_q.push_back({1'b0, 8'h5A});
        wait_done("t3");
        chk("t3_ready_count", rdy_cyc.size(), 5);
        if (rdy_cyc.size() == 5) begin
            for (int i = 0; i < 3; i++) chk("t3_byte_time", rdy_cyc[i+1] - rdy_cyc[i], 7);
            chk("t3_siwu_delay", siwu_fall_cyc - rdy_cyc[3], 7);
            chk("t3_req0_after_siwu", rdy_cyc[4] - rdy_cyc[3], 10);
        end

        // Host read preempting mid-packet
        rdy_cyc.delete();
        r1_q.push_back({1'b0, 8'h20});
        r1_q.push_back({1'b0, 8'h21});
        r1_q.push_back({1'b1, 8'h22});
        r0_q.push_back(8'h77);
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b1, 8'h21});
        exp_q.push_back({1'b1, 8'h22});
        exp_q.push_back({1'b0, 8'h77});
        wait_ready_count(2, "t4_byte2");
        host_q.push_back(8'h99);
        cmd_exp.push_back(8'h99);
        wait_done("t4");
        chk("t4_ready_count", rdy_cyc.size(), 4);
        if (rdy_cyc.size() == 4) chk("t4_read_between", int'(cmd_cyc > rdy_cyc[1] && cmd_cyc < rdy_cyc[2]), 1);

        // TXE# high mid-packet; locked packet resumes, MCP waits
        rdy_cyc.delete();
        r1_q.push_back({1'b0, 8'h30});
        r1_q.push_back({1'b0, 8'h31});
        r1_q.push_back({1'b1, 8'h32});
        r0_q.push_back(8'h66);
        exp_q.push_back({1'b1, 8'h30});
        exp_q.push_back({1'b1, 8'h31});
        exp_q.push_back({1'b1, 8'h32});
        exp_q.push_back({1'b0, 8'h66});
        wait_ready_count(1, "t5_first");
        ft_txe_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (i >= 8 && (req0_ready || req1_ready || !ft_wr_n)) bad++;
        end
        chk("t5_quiet", bad, 0);
        chk("t5_pending", exp_q.size(), 3);
        ft_txe_n = 1'b0;
        wait_done("t5");

        // Reset during WR_STROBE aborts; MCP granted first afterwards
        r1_q.push_back({1'b0, 8'h40});
        r1_q.push_back({1'b1, 8'h41});
        r0_q.push_back(8'h55);
        exp_q.push_back({1'b1, 8'h40});
        n = 0;
        while (ft_wr_n && n < 100) begin @(negedge clk_in); n++; end
        chk("t6_saw_strobe", int'(ft_wr_n), 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_wr_n", int'(ft_wr_n), 1);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_strobes", int'({ft_rd_n, ft_oe_n, ft_siwu_n}), 7);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b1, 8'h41});
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        wait_done("t6");

        chk("final_exp_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
